crc8_word_checker: RTL

//  Sequencer for the crc_8 engine in the I2C read path. Takes the received byte stream
//  as groups of DATA_BYTES data bytes plus 1 CRC byte (e.g. MSB, LSB, CRC).

---
 rtl/crc8_pkg.sv | 24 ++
 rtl/crc_8.sv | 42 ++++
 rtl/crc8_word_checker.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared constants, FSM state encoding and the single-bit CRC-8 step used by the
// word checker and its crc_8 engine.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY        = 8'h31;
  localparam logic [7:0] CRC8_INIT        = 8'hFF;
  localparam logic [3:0] CRC8_BUSY_CYCLES = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENG_RST,
    ST_RUN,
    ST_WAIT,
    ST_FEED,
    ST_GETCRC,
    ST_OUT
  } state_e;

  // One MSB-first shift of the CRC register with polynomial reduction.
  function automatic logic [7:0] crc8_shift(input logic [7:0] c);
    return c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/crc_8.sv
// Bit-serial CRC-8 engine: a run rising edge folds one byte into the running CRC.
// It is busy for 10 cycles afterwards, and ready_o reports when crc_o is valid.
module crc_8
  import crc8_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [3:0] cnt_q;
  logic       run_q;

  // The byte is XORed in on the edge, then reduced over the first 8 busy cycles;
  // the last two busy cycles are idle padding before ready returns.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      crc_q <= CRC8_INIT;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= run_i;
      if (run_i && !run_q) begin
        crc_q <= crc_q ^ data_i;
        cnt_q <= CRC8_BUSY_CYCLES;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q > 4'd2) begin
          crc_q <= crc8_shift(crc_q);
        end
      end
    end
  end

  assign ready_o = (cnt_q == 4'd0);
  assign crc_o   = crc_q;

endmodule

// File: rtl/crc8_word_checker.sv
// Collects DATA_BYTES data bytes plus one CRC byte, runs the data through the crc_8
// engine and reports the word with a CRC pass/fail flag and a saturating error count.
module crc8_word_checker
  import crc8_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [8*DATA_BYTES-1:0] out_data_o,
  output logic                    out_crc_ok_o,
  output logic                    out_last_o,
  output logic                    frame_err_o,
  output logic [ERR_CNT_W-1:0]    err_count_o,
  output logic                    busy_o
);

  localparam int         DW       = 8 * DATA_BYTES;
  localparam logic [2:0] LAST_CNT = 3'(DATA_BYTES);

  state_e                 state_q, state_d;
  logic [DW-1:0]          data_q, data_d;
  logic [7:0]             cur_q, cur_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   ok_q, ok_d;
  logic                   last_q, last_d;
  logic                   frame_q, frame_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d, err_inc;

  logic                   eng_rst_n, eng_run, eng_ready;
  logic [7:0]             eng_crc;
  logic                   accept;

  crc_8 u_engine (
    .clk_i   (clk_i),
    .rst_n_i (eng_rst_n),
    .run_i   (eng_run),
    .data_i  (cur_q),
    .ready_o (eng_ready),
    .crc_o   (eng_crc)
  );

  assign eng_rst_n = ~(rst_i | (state_q == ST_ENG_RST));
  assign accept    = in_valid_i & in_ready_o;
  assign err_inc   = (err_q == '1) ? err_q : err_q + ERR_CNT_W'(1);

  // Any data byte carrying in_last ends the transaction before its CRC byte.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    ok_d       = ok_q;
    last_d     = last_q;
    err_d      = err_q;
    frame_d    = 1'b0;
    in_ready_o = 1'b0;
    eng_run    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (accept) begin
          data_d = DW'(in_data_i);
          cur_d  = in_data_i;
          cnt_d  = 3'd1;
          if (in_last_i) begin
            frame_d = 1'b1;
            err_d   = err_inc;
          end else begin
            state_d = ST_ENG_RST;
          end
        end
      end
      ST_ENG_RST: state_d = ST_RUN;
      ST_RUN: begin
        eng_run = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_ready) begin
          state_d = (cnt_q < LAST_CNT) ? ST_FEED : ST_GETCRC;
        end
      end
      ST_FEED: begin
        in_ready_o = 1'b1;
        if (accept) begin
          data_d = (data_q << 8) | DW'(in_data_i);
          cur_d  = in_data_i;
          cnt_d  = cnt_q + 3'd1;
          if (in_last_i) begin
            frame_d = 1'b1;
            err_d   = err_inc;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_GETCRC: begin
        in_ready_o = 1'b1;
        if (accept) begin
          ok_d    = (in_data_i == eng_crc);
          last_d  = in_last_i;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (!ok_q) begin
          err_d = err_inc;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      last_q  <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o  = (state_q == ST_OUT);
  assign out_data_o   = data_q;
  assign out_crc_ok_o = ok_q;
  assign out_last_o   = last_q;
  assign frame_err_o  = frame_q;
  assign err_count_o  = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
